compare_pipe: RTL and testbench

Parametrised, two-stage pipelined comparison unit for the execution-event path. Each transaction carries a thread register file, a flag vector and a compare opcode; the unit selects two registers, evaluates one of eight compare modes and writes the result into one flag bit (replace, AND or OR). Results leave through a valid/ready output port. It supersedes the single-cycle combinational compare function, which supported only unsigned less-than and equality at a fixed 32-bit width.

---
 rtl/compare_pipe_if.sv | 34 +++
 rtl/compare_pipe.sv | 147 ++++++++++++++
 tb/tb_compare_pipe.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/compare_pipe_if.sv
// Transaction bus for compare_pipe: input request side and output result side.
// master drives requests and out_ready; slave is the compare unit.
interface compare_pipe_if #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int NUM_FLAGS = 8,
  parameter int RIDX_W    = $clog2(NUM_REGS),
  parameter int FIDX_W    = $clog2(NUM_FLAGS) + 1
);
  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_REGS*DATA_W-1:0]   in_regs;
  logic [NUM_FLAGS-1:0]         in_flags;
  logic [RIDX_W-1:0]            in_ra;
  logic [RIDX_W-1:0]            in_rb;
  logic [2:0]                   in_mode;
  logic [1:0]                   in_comb;
  logic [FIDX_W-1:0]            in_fidx;
  logic                         out_valid;
  logic                         out_ready;
  logic [NUM_FLAGS-1:0]         out_flags;
  logic                         out_res;
  logic                         out_err;

  modport master (
    output in_valid, in_regs, in_flags, in_ra, in_rb, in_mode, in_comb, in_fidx, out_ready,
    input  in_ready, out_valid, out_flags, out_res, out_err
  );

  modport slave (
    input  in_valid, in_regs, in_flags, in_ra, in_rb, in_mode, in_comb, in_fidx, out_ready,
    output in_ready, out_valid, out_flags, out_res, out_err
  );
endinterface

// File: rtl/compare_pipe.sv
// Two-stage pipelined register compare with flag-bit write-back (replace/AND/OR)
// and a valid/ready result port. S1 captures operands, S2 captures the result.

// One flag bit: decides whether this bit is the destination and how it combines.
module compare_pipe_lane #(
  parameter int FIDX_W = 4,
  parameter int IDX    = 0
) (
  input  logic [FIDX_W-1:0] fidx,
  input  logic              err,
  input  logic              old,
  input  logic              res,
  input  logic [1:0]        comb,
  output logic              nxt
);
  always_comb begin
    nxt = old;
    if (!err && fidx == FIDX_W'(IDX)) begin
      case (comb)
        2'd1:    nxt = old & res;
        2'd2:    nxt = old | res;
        default: nxt = res;
      endcase
    end
  end
endmodule

module compare_pipe #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int NUM_FLAGS = 8,
  parameter int RIDX_W    = $clog2(NUM_REGS),
  parameter int FIDX_W    = $clog2(NUM_FLAGS) + 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  compare_pipe_if.slave    bus,
  output logic [CNT_W-1:0] cmp_count
);
  localparam logic [2:0] MODE_LTU = 3'd0;
  localparam logic [2:0] MODE_EQ  = 3'd1;
  localparam logic [2:0] MODE_GTU = 3'd2;
  localparam logic [2:0] MODE_NE  = 3'd3;
  localparam logic [2:0] MODE_LEU = 3'd4;
  localparam logic [2:0] MODE_GEU = 3'd5;
  localparam logic [2:0] MODE_LTS = 3'd6;
  localparam logic [2:0] MODE_GTS = 3'd7;

  typedef struct packed {
    logic [DATA_W-1:0]    a;
    logic [DATA_W-1:0]    b;
    logic [NUM_FLAGS-1:0] flags;
    logic [2:0]           mode;
    logic [1:0]           comb;
    logic [FIDX_W-1:0]    fidx;
  } s1_t;

  function automatic logic cmp(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                               input logic [2:0] mode);
    logic r;
    case (mode)
      MODE_LTU: r = a < b;
      MODE_EQ:  r = a == b;
      MODE_GTU: r = a > b;
      MODE_NE:  r = a != b;
      MODE_LEU: r = a <= b;
      MODE_GEU: r = a >= b;
      MODE_LTS: r = $signed(a) < $signed(b);
      MODE_GTS: r = $signed(a) > $signed(b);
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

  logic [2:1]                        vld_pipe;
  logic                              s1_adv, s2_adv, acc;
  logic [NUM_REGS-1:0][DATA_W-1:0]   rf;
  s1_t                               s1_d, s1_q;
  logic                              res_d, err_d;
  logic [NUM_FLAGS-1:0]              flags_d;
  logic                              res_q, err_q;
  logic [NUM_FLAGS-1:0]              flags_q;

  assign s2_adv       = !vld_pipe[2] || bus.out_ready;
  assign s1_adv       = !vld_pipe[1] || s2_adv;
  assign bus.in_ready = s1_adv && !rst;
  assign acc          = bus.in_valid && bus.in_ready;

  // Only the two selected operands survive S1; the register file is dropped here.
  assign rf = bus.in_regs;
  always_comb begin
    s1_d       = '0;
    s1_d.a     = rf[bus.in_ra];
    s1_d.b     = rf[bus.in_rb];
    s1_d.flags = bus.in_flags;
    s1_d.mode  = bus.in_mode;
    s1_d.comb  = bus.in_comb;
    s1_d.fidx  = bus.in_fidx;
  end

  assign res_d = cmp(s1_q.a, s1_q.b, s1_q.mode);
  assign err_d = s1_q.fidx >= FIDX_W'(NUM_FLAGS);

  for (genvar i = 0; i < NUM_FLAGS; i++) begin : g_lane
    compare_pipe_lane #(.FIDX_W(FIDX_W), .IDX(i)) u_lane (
      .fidx (s1_q.fidx),
      .err  (err_d),
      .old  (s1_q.flags[i]),
      .res  (res_d),
      .comb (s1_q.comb),
      .nxt  (flags_d[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      res_q    <= 1'b0;
      err_q    <= 1'b0;
      flags_q  <= '0;
    end else begin
      if (s1_adv) vld_pipe[1] <= bus.in_valid;
      if (acc)    s1_q        <= s1_d;
      // Output data only moves on s2_adv, so it holds while stalled.
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          res_q   <= res_d;
          err_q   <= err_d;
          flags_q <= flags_d;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              cmp_count <= '0;
    else if (vld_pipe[2] && bus.out_ready) cmp_count <= cmp_count + CNT_W'(1);
  end

  assign bus.out_valid = vld_pipe[2];
  assign bus.out_res   = res_q;
  assign bus.out_err   = err_q;
  assign bus.out_flags = flags_q;
endmodule

// File: tb/tb_compare_pipe.sv
// Directed bench for compare_pipe: compare modes, flag combine, error index,
// backpressure, mid-flight reset and counter wrap (second instance, CNT_W=4).
module tb_compare_pipe;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int NF = 8;

  logic        clk;
  logic        rst;
  logic [15:0] cmp_count;
  logic [3:0]  cmp_count2;
  int          errors;
  int          checks;

  compare_pipe_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_FLAGS(NF)) b  ();
  compare_pipe_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_FLAGS(NF)) b2 ();

  compare_pipe #(.DATA_W(DW), .NUM_REGS(NR), .NUM_FLAGS(NF), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(b), .cmp_count(cmp_count));
  compare_pipe #(.DATA_W(DW), .NUM_REGS(NR), .NUM_FLAGS(NF), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .bus(b2), .cmp_count(cmp_count2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int ra, input int rb, input logic [31:0] a, input logic [31:0] bv,
                         input logic [2:0] m, input logic [1:0] cb, input logic [3:0] fi,
                         input logic [7:0] fl);
    logic [NR*DW-1:0] regs;
    for (int i = 0; i < NR; i++) regs[i*DW +: DW] = 32'hC0DE_0000 + i;
    regs[ra*DW +: DW] = a;
    regs[rb*DW +: DW] = bv;
    b.in_regs  = regs;
    b.in_ra    = 4'(ra);
    b.in_rb    = 4'(rb);
    b.in_mode  = m;
    b.in_comb  = cb;
    b.in_fidx  = fi;
    b.in_flags = fl;
  endtask

  // Runs one transaction on an idle pipe; called #1 after a rising edge.
  task automatic txn(input int ra, input int rb, input logic [31:0] a, input logic [31:0] bv,
                     input logic [2:0] m, input logic [1:0] cb, input logic [3:0] fi,
                     input logic [7:0] fl, output int lat, output logic r,
                     output logic [7:0] of, output logic e);
    set_req(ra, rb, a, bv, m, cb, fi, fl);
    b.out_ready = 1'b1;
    b.in_valid  = 1'b1;
    @(posedge clk); #1;
    b.in_valid = 1'b0;
    lat = 1;
    while (!b.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    r  = b.out_res;
    of = b.out_flags;
    e  = b.out_err;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks += 6;
    if (b.in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got=%b exp=0", b.in_ready); end
    if (b.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", b.out_valid); end
    if (b.out_res !== 1'b0)   begin errors++; $display("FAIL reset_out_res got=%b exp=0", b.out_res); end
    if (b.out_err !== 1'b0)   begin errors++; $display("FAIL reset_out_err got=%b exp=0", b.out_err); end
    if (b.out_flags !== 8'h00) begin errors++; $display("FAIL reset_out_flags got=%h exp=00", b.out_flags); end
    if (cmp_count !== 16'd0)  begin errors++; $display("FAIL reset_cmp_count got=%0d exp=0", cmp_count); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic r, e; logic [7:0] of;
    txn(3, 4, 32'd15, 32'd110, 3'd0, 2'd0, 4'd0, 8'h00, lat, r, of, e);
    checks += 4;
    if (lat !== 2)     begin errors++; $display("FAIL basic_latency got=%0d exp=2", lat); end
    if (r !== 1'b1)    begin errors++; $display("FAIL basic_res got=%b exp=1", r); end
    if (of !== 8'h01)  begin errors++; $display("FAIL basic_flags got=%h exp=01", of); end
    if (e !== 1'b0)    begin errors++; $display("FAIL basic_err got=%b exp=0", e); end
  endtask

  task automatic test_combine();
    int lat; logic r, e; logic [7:0] of;
    txn(5, 6, 32'd36, 32'd36, 3'd1, 2'd0, 4'd1, 8'h01, lat, r, of, e);
    checks += 2;
    if (r !== 1'b1)   begin errors++; $display("FAIL eq_res got=%b exp=1", r); end
    if (of !== 8'h03) begin errors++; $display("FAIL eq_flags got=%h exp=03", of); end
    txn(5, 6, 32'd36, 32'd36, 3'd3, 2'd1, 4'd1, 8'h03, lat, r, of, e);
    checks += 2;
    if (r !== 1'b0)   begin errors++; $display("FAIL ne_and_res got=%b exp=0", r); end
    if (of !== 8'h01) begin errors++; $display("FAIL ne_and_flags got=%h exp=01", of); end
    txn(2, 9, 32'd50, 32'd7, 3'd2, 2'd2, 4'd3, 8'h10, lat, r, of, e);
    checks += 2;
    if (r !== 1'b1)   begin errors++; $display("FAIL gtu_or_res got=%b exp=1", r); end
    if (of !== 8'h18) begin errors++; $display("FAIL gtu_or_flags got=%h exp=18", of); end
    txn(2, 9, 32'd7, 32'd7, 3'd4, 2'd3, 4'd0, 8'hF0, lat, r, of, e);
    checks += 2;
    if (r !== 1'b1)   begin errors++; $display("FAIL leu_rsvd_res got=%b exp=1", r); end
    if (of !== 8'hF1) begin errors++; $display("FAIL leu_rsvd_flags got=%h exp=f1", of); end
    txn(2, 9, 32'd6, 32'd7, 3'd5, 2'd0, 4'd7, 8'hFF, lat, r, of, e);
    checks += 2;
    if (r !== 1'b0)   begin errors++; $display("FAIL geu_res got=%b exp=0", r); end
    if (of !== 8'h7F) begin errors++; $display("FAIL geu_flags got=%h exp=7f", of); end
  endtask

  task automatic test_signed();
    int lat; logic r, e; logic [7:0] of;
    txn(0, 1, 32'hFFFF_FFFF, 32'd1, 3'd0, 2'd0, 4'd2, 8'h00, lat, r, of, e);
    checks += 1;
    if (r !== 1'b0) begin errors++; $display("FAIL ltu_neg_res got=%b exp=0", r); end
    txn(0, 1, 32'hFFFF_FFFF, 32'd1, 3'd6, 2'd0, 4'd2, 8'h00, lat, r, of, e);
    checks += 2;
    if (r !== 1'b1)   begin errors++; $display("FAIL lts_res got=%b exp=1", r); end
    if (of !== 8'h04) begin errors++; $display("FAIL lts_flags got=%h exp=04", of); end
    txn(0, 1, 32'hFFFF_FFFF, 32'd1, 3'd7, 2'd0, 4'd2, 8'h00, lat, r, of, e);
    checks += 1;
    if (r !== 1'b0) begin errors++; $display("FAIL gts_res got=%b exp=0", r); end
  endtask

  task automatic test_err();
    int lat; logic r, e; logic [7:0] of;
    txn(5, 6, 32'd9, 32'd9, 3'd1, 2'd0, 4'd8, 8'hA5, lat, r, of, e);
    checks += 3;
    if (e !== 1'b1)   begin errors++; $display("FAIL err_flag got=%b exp=1", e); end
    if (of !== 8'hA5) begin errors++; $display("FAIL err_flags got=%h exp=a5", of); end
    if (r !== 1'b1)   begin errors++; $display("FAIL err_res got=%b exp=1", r); end
  endtask

  task automatic test_back_to_back();
    int sent, got;
    logic accepted, held_set;
    logic [7:0] held;
    logic [7:0] got_flags [4];
    do_reset();
    sent = 0; got = 0; held_set = 1'b0; held = 8'h00;
    for (int c = 0; c < 30 && got < 4; c++) begin
      b.out_ready = !(c >= 2 && c <= 5);
      if (sent < 4) begin
        set_req(0, 1, 32'd7, 32'd7, 3'd1, 2'd0, 4'd7, 8'(sent));
        b.in_valid = 1'b1;
      end else b.in_valid = 1'b0;
      #1;
      if (c == 2) begin
        checks++;
        if (b.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got=%b exp=0", b.in_ready); end
      end
      if (b.out_valid && !b.out_ready) begin
        if (!held_set) begin held = b.out_flags; held_set = 1'b1; end
        else begin
          checks++;
          if (b.out_flags !== held) begin errors++; $display("FAIL bp_hold got=%h exp=%h", b.out_flags, held); end
        end
      end
      if (b.out_valid && b.out_ready) begin
        got_flags[got] = b.out_flags;
        got++;
      end
      accepted = b.in_valid && b.in_ready;
      @(posedge clk); #1;
      if (accepted) sent++;
    end
    b.in_valid = 1'b0;
    b.out_ready = 1'b1;
    checks += 3;
    if (got !== 4)          begin errors++; $display("FAIL bp_count got=%0d exp=4", got); end
    if (b.out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup got=%b exp=0", b.out_valid); end
    if (cmp_count !== 16'd4) begin errors++; $display("FAIL bp_cmp_count got=%0d exp=4", cmp_count); end
    for (int i = 0; i < 4 && i < got; i++) begin
      checks++;
      if (got_flags[i] !== (8'h80 | 8'(i)))
        begin errors++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, got_flags[i], 8'h80 | 8'(i)); end
    end
  endtask

  task automatic test_midreset();
    int lat, seen; logic r, e; logic [7:0] of;
    b.out_ready = 1'b0;
    set_req(3, 4, 32'd1, 32'd2, 3'd0, 2'd0, 4'd0, 8'h00);
    b.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    b.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (b.out_valid !== 1'b0) begin errors++; $display("FAIL mr_out_valid got=%b exp=0", b.out_valid); end
    if (b.in_ready !== 1'b0)  begin errors++; $display("FAIL mr_in_ready got=%b exp=0", b.in_ready); end
    if (cmp_count !== 16'd0)  begin errors++; $display("FAIL mr_cmp_count got=%0d exp=0", cmp_count); end
    b.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (b.out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL mr_ghost got=%0d exp=0", seen); end
    txn(3, 4, 32'd20, 32'd10, 3'd7, 2'd0, 4'd5, 8'h00, lat, r, of, e);
    checks += 2;
    if (lat !== 2)    begin errors++; $display("FAIL mr_latency got=%0d exp=2", lat); end
    if (of !== 8'h20) begin errors++; $display("FAIL mr_flags got=%h exp=20", of); end
  endtask

  task automatic test_wrap();
    do_reset();
    b2.out_ready = 1'b1;
    b2.in_valid  = 1'b1;
    repeat (17) @(posedge clk);
    #1;
    b2.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (cmp_count2 !== 4'd1) begin errors++; $display("FAIL wrap_cmp_count got=%0d exp=1", cmp_count2); end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1;
    b.in_valid = 1'b0; b.out_ready = 1'b1; b.in_regs = '0; b.in_flags = '0;
    b.in_ra = '0; b.in_rb = '0; b.in_mode = '0; b.in_comb = '0; b.in_fidx = '0;
    b2.in_valid = 1'b0; b2.out_ready = 1'b1; b2.in_regs = '0; b2.in_flags = '0;
    b2.in_ra = '0; b2.in_rb = '0; b2.in_mode = '0; b2.in_comb = '0; b2.in_fidx = '0;
    test_reset();
    @(posedge clk); #1;
    test_basic();
    test_combine();
    test_signed();
    test_err();
    test_back_to_back();
    test_midreset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
